piece_collision_checker: RTL

//  Parametrised collision checker for a candidate tetromino placement. On start it latches an anchor
//  and per-cell offsets, reads each covered cell from the board RAM, and reports occupancy and
//  out-of-bounds in a single result.

---
 rtl/piece_collision_checker_if.sv | 37 +++
 rtl/piece_collision_checker.sv | 132 +++++++++++++
 2 files changed

// File: rtl/piece_collision_checker_if.sv
// Request/result and board-RAM read signals of the piece collision checker.
// master: game control plus board RAM; slave: the checker itself.
interface piece_collision_checker_if #(
    parameter int CELLS  = 4,
    parameter int OFF_W  = 2,
    parameter int X_W    = 5,
    parameter int Y_W    = 6,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 6
);
    logic                   start;
    logic [X_W-1:0]         x_anchor;
    logic [Y_W-1:0]         y_anchor;
    logic [CELLS*OFF_W-1:0] cell_dx;
    logic [CELLS*OFF_W-1:0] cell_dy;
    logic [ADDR_W-1:0]      ram_addr;
    logic                   ram_rd;
    logic [DATA_W-1:0]      ram_q;
    logic                   busy;
    logic                   done;
    logic                   collision;
    logic                   oob;

    modport master (
        output start, x_anchor, y_anchor,
        output cell_dx, cell_dy, ram_q,
        input  ram_addr, ram_rd, busy,
        input  done, collision, oob
    );

    modport slave (
        input  start, x_anchor, y_anchor,
        input  cell_dx, cell_dy, ram_q,
        output ram_addr, ram_rd, busy,
        output done, collision, oob
    );
endinterface

// File: rtl/piece_collision_checker.sv
// Checks a candidate tetromino placement against the board RAM and bounds.
// Optional EARLY_ABORT_EN: stop issuing reads once a collision is known.
module piece_collision_checker #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 24,
    parameter int CELLS   = 4,
    parameter int OFF_W   = 2,
    parameter int X_W     = 5,
    parameter int Y_W     = 6,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 6,
    parameter int RAM_LAT = 1
) (
    input logic                      clk,
    input logic                      reset,
    piece_collision_checker_if.slave bus
);
    localparam int KW = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int CW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
`ifdef EARLY_ABORT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE, ISSUE, DRAIN, DONE
    } state_t;

    state_t                 state;
    logic [X_W-1:0]         x_l;
    logic [Y_W-1:0]         y_l;
    logic [CELLS*OFF_W-1:0] dx_l;
    logic [CELLS*OFF_W-1:0] dy_l;
    logic [KW-1:0]          k;
    logic [CW-1:0]          cnt;
    logic [RAM_LAT-1:0]     vld;

    logic [OFF_W-1:0]  dx_k;
    logic [OFF_W-1:0]  dy_k;
    logic [X_W:0]      cx;
    logic [Y_W:0]      cy;
    logic [ADDR_W-1:0] addr_k;
    logic              cell_oob;
    logic              hit;
    logic              last;
    logic              stop_now;

    // One extra bit on cx/cy so anchor+offset never wraps back on-board
    always_comb begin
        dx_k     = OFF_W'(dx_l >> (OFF_W * int'(k)));
        dy_k     = OFF_W'(dy_l >> (OFF_W * int'(k)));
        cx       = {1'b0, x_l} + (X_W+1)'(dx_k);
        cy       = {1'b0, y_l} + (Y_W+1)'(dy_k);
        cell_oob = (cx >= (X_W+1)'(BOARD_W)) ||
                   (cy >= (Y_W+1)'(BOARD_H));
        addr_k   = ADDR_W'(int'(cy) * BOARD_W + int'(cx));
        hit      = vld[RAM_LAT-1] & (|bus.ram_q);
        last     = (k == KW'(CELLS-1));
        stop_now = EARLY & (bus.collision | hit);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            x_l           <= '0;
            y_l           <= '0;
            dx_l          <= '0;
            dy_l          <= '0;
            k             <= '0;
            cnt           <= '0;
            vld           <= '0;
            bus.ram_addr  <= '0;
            bus.ram_rd    <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.collision <= 1'b0;
            bus.oob       <= 1'b0;
        end else begin
            vld        <= (vld << 1) | RAM_LAT'(bus.ram_rd);
            bus.ram_rd <= 1'b0;
            bus.done   <= 1'b0;
            if (hit)
                bus.collision <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        x_l           <= bus.x_anchor;
                        y_l           <= bus.y_anchor;
                        dx_l          <= bus.cell_dx;
                        dy_l          <= bus.cell_dy;
                        k             <= '0;
                        bus.collision <= 1'b0;
                        bus.oob       <= 1'b0;
                        bus.busy      <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (stop_now) begin
                        cnt   <= '0;
                        state <= DRAIN;
                    end else begin
                        if (cell_oob) begin
                            bus.oob       <= 1'b1;
                            bus.collision <= 1'b1;
                        end else begin
                            bus.ram_addr <= addr_k;
                            bus.ram_rd   <= 1'b1;
                        end
                        k <= k + KW'(1);
                        if (last || (EARLY && cell_oob)) begin
                            cnt   <= '0;
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt == CW'(RAM_LAT-1))
                        state <= DONE;
                    else
                        cnt <= cnt + CW'(1);
                end
                DONE: begin
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule
